// File: rtl/switch_debouncer.sv
// Multi-channel debouncer for raw active-low switch pins: synchronizes each pin,
// then accepts a level change only after it has held for DEBOUNCE_CYCLES cycles.
module switch_debouncer #(
    parameter int NUM_SWITCHES    = 2,
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_SWITCHES-1:0] switch_n,
    output logic [NUM_SWITCHES-1:0] pressed,
    output logic [NUM_SWITCHES-1:0] press_pulse,
    output logic [NUM_SWITCHES-1:0] release_pulse,
    output logic [NUM_SWITCHES-1:0] toggle
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
            $error("switch_debouncer: DEBOUNCE_CYCLES must be at least 2");
        end
    endgenerate

    // Synchronizer resets to the released level so reset never looks like a press.
    logic [NUM_SWITCHES-1:0] sync1;
    logic [NUM_SWITCHES-1:0] sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= switch_n;
            sync2 <= sync1;
        end
    end

    genvar ch;
    generate
        for (ch = 0; ch < NUM_SWITCHES; ch++) begin : g_chan
            logic [CW-1:0] count;
            logic          pressed_q;
            logic          press_q;
            logic          release_q;
            logic          toggle_q;
            logic          differs;

            // sync2 is active-low, so equality with pressed means disagreement.
            assign differs = (sync2[ch] == pressed_q);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count     <= '0;
                    pressed_q <= 1'b0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                    toggle_q  <= 1'b0;
                end else begin
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                    if (differs) begin
                        if (count == LAST_COUNT) begin
                            count     <= '0;
                            pressed_q <= ~pressed_q;
                            if (!pressed_q) begin
                                press_q  <= 1'b1;
                                toggle_q <= ~toggle_q;
                            end else begin
                                release_q <= 1'b1;
                            end
                        end else begin
                            count <= count + CW'(1);
                        end
                    end else begin
                        count <= '0;
                    end
                end
            end

            assign pressed[ch]       = pressed_q;
            assign press_pulse[ch]   = press_q;
            assign release_pulse[ch] = release_q;
            assign toggle[ch]        = toggle_q;
        end
    endgenerate

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with DEBOUNCE_CYCLES = 4 and two channels:
// a vector table covers clean presses, bounces and dual-channel events; reset mid-count is hand-written.
module tb_switch_debouncer;

    localparam int NS = 2;
    localparam int DC = 4;

    logic          clk;
    logic          rst_n;
    logic [NS-1:0] switch_n;
    logic [NS-1:0] pressed;
    logic [NS-1:0] press_pulse;
    logic [NS-1:0] release_pulse;
    logic [NS-1:0] toggle;

    int total;
    int bad;

    switch_debouncer #(
        .NUM_SWITCHES   (NS),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .switch_n     (switch_n),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .toggle       (toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NS-1:0] sw;
        int            n;
        logic [NS-1:0] p;
        logic [NS-1:0] pp;
        logic [NS-1:0] rp;
        logic [NS-1:0] t;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [NS-1:0] sw, input int n, input logic [NS-1:0] p,
                       input logic [NS-1:0] pp, input logic [NS-1:0] rp, input logic [NS-1:0] t);
        vec_t v;
        v.sw = sw; v.n = n; v.p = p; v.pp = pp; v.rp = rp; v.t = t;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [NS-1:0] act,
                         input logic [NS-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [NS-1:0] p, input logic [NS-1:0] pp,
                             input logic [NS-1:0] rp, input logic [NS-1:0] t);
        check("pressed", idx, pressed, p);
        check("press_pulse", idx, press_pulse, pp);
        check("release_pulse", idx, release_pulse, rp);
        check("toggle", idx, toggle, t);
    endtask

    // Advance n rising edges, sampling 1 time unit after each edge; strobes must never overlap.
    task automatic advance(input int n, input int idx);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            check("strobe_overlap", idx, press_pulse & release_pulse, '0);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        switch_n = 2'b11;
        #1;
        check_all(-1, 2'b00, 2'b00, 2'b00, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle with switches released.
        add(2'b11, 20, 2'b00, 2'b00, 2'b00, 2'b00);
        // Clean press on channel 0: accepted on the 6th edge.
        add(2'b10, 5, 2'b00, 2'b00, 2'b00, 2'b00);
        add(2'b10, 1, 2'b01, 2'b01, 2'b00, 2'b01);
        add(2'b10, 1, 2'b01, 2'b00, 2'b00, 2'b01);
        // Release channel 0: toggle holds.
        add(2'b11, 5, 2'b01, 2'b00, 2'b00, 2'b01);
        add(2'b11, 1, 2'b00, 2'b00, 2'b01, 2'b01);
        add(2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b01);
        // Bounce: low 3, high 1, five times, never accepted.
        for (int r = 0; r < 5; r++) begin
            add(2'b10, 3, 2'b00, 2'b00, 2'b00, 2'b01);
            add(2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b01);
        end
        add(2'b11, 6, 2'b00, 2'b00, 2'b00, 2'b01);
        // Channel 1 press, release, press, release.
        add(2'b01, 5, 2'b00, 2'b00, 2'b00, 2'b01);
        add(2'b01, 1, 2'b10, 2'b10, 2'b00, 2'b11);
        add(2'b01, 1, 2'b10, 2'b00, 2'b00, 2'b11);
        add(2'b11, 5, 2'b10, 2'b00, 2'b00, 2'b11);
        add(2'b11, 1, 2'b00, 2'b00, 2'b10, 2'b11);
        add(2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b11);
        add(2'b01, 5, 2'b00, 2'b00, 2'b00, 2'b11);
        add(2'b01, 1, 2'b10, 2'b10, 2'b00, 2'b01);
        add(2'b01, 1, 2'b10, 2'b00, 2'b00, 2'b01);
        add(2'b11, 5, 2'b10, 2'b00, 2'b00, 2'b01);
        add(2'b11, 1, 2'b00, 2'b00, 2'b10, 2'b01);
        add(2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b01);
        // Both channels pressed then released on the same edge.
        add(2'b00, 5, 2'b00, 2'b00, 2'b00, 2'b01);
        add(2'b00, 1, 2'b11, 2'b11, 2'b00, 2'b10);
        add(2'b00, 1, 2'b11, 2'b00, 2'b00, 2'b10);
        add(2'b11, 5, 2'b11, 2'b00, 2'b00, 2'b10);
        add(2'b11, 1, 2'b00, 2'b00, 2'b11, 2'b10);
        add(2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b10);

        foreach (vecs[i]) begin
            switch_n = vecs[i].sw;
            advance(vecs[i].n, i);
            check_all(i, vecs[i].p, vecs[i].pp, vecs[i].rp, vecs[i].t);
        end

        // Reset while channel 0 counter is at 2 with the switch still held.
        switch_n = 2'b10;
        advance(4, 100);
        check_all(100, 2'b00, 2'b00, 2'b00, 2'b10);
        rst_n = 1'b0;
        #1;
        check_all(101, 2'b00, 2'b00, 2'b00, 2'b00);
        advance(2, 102);
        check_all(102, 2'b00, 2'b00, 2'b00, 2'b00);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            advance(1, 102 + k);
            check_all(102 + k, 2'b00, 2'b00, 2'b00, 2'b00);
        end
        advance(1, 108);
        check_all(108, 2'b01, 2'b01, 2'b00, 2'b01);
        advance(1, 109);
        check_all(109, 2'b01, 2'b00, 2'b00, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
